exec_unit: RTL and testbench

Single-issue execute stage that sits directly downstream of the 4-entry register file read ports and upstream of its write port. It accepts an operation plus two operand values under a valid/ready handshake, computes ADD/SUB/AND in one cycle or MUL iteratively, and issues one write-back beat (`write_enable`/`write_index`/`write_data`) to the register file. Register 0 is read-as-zero in the register file, so this block never issues a write to index 0.

---
 rtl/exec_pkg.sv | 22 ++
 rtl/mul_seq.sv | 77 +++++++
 rtl/exec_unit.sv | 154 +++++++++++++++
 tb/tb_exec_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared types and constants for the exec_unit execute stage.
// Operation and state encodings plus the iterative multiplier cycle count.
package exec_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_MUL = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // One multiplier bit is consumed per cycle, so a full product takes 32 cycles.
    localparam int MUL_CYCLES = 32;
    localparam int MUL_CNT_W  = 5;

endpackage

// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add multiplier, one multiplier bit per cycle.
// done_o is high during the last step; product_o is valid in that same cycle
// (it already includes the final partial product), so the caller can register
// it on the edge that ends the multiply.
module mul_seq
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    logic                 running_q, running_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     addend_s;
    logic [WIDTH-1:0]     sum_s;

    assign addend_s  = mplier_q[0] ? mcand_q : '0;
    assign sum_s     = acc_q + addend_s;
    assign done_o    = running_q && (cnt_q == MUL_CNT_W'(MUL_CYCLES - 1));
    assign product_o = sum_s;

    // Next-state: load operands on start, otherwise accumulate and shift while running.
    always_comb begin
        running_d = running_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        if (start_i) begin
            running_d = 1'b1;
            cnt_d     = '0;
            mcand_d   = a_i;
            mplier_d  = b_i;
            acc_d     = '0;
        end else if (running_q) begin
            acc_d    = sum_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (done_o) begin
                running_d = 1'b0;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + MUL_CNT_W'(1);
            end
        end else begin
            running_d = 1'b0;
        end
    end

    // Multiplier state registers, cleared asynchronously so a reset aborts a multiply.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
        end else begin
            running_q <= running_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: single-issue execute stage between register-file read and write ports.
// ADD/SUB/AND complete in one cycle; MUL is iterative through mul_seq.
// Build option EXEC_MUL_EN: when defined the multiplier is present; when not,
// an accepted MUL pulses err for one cycle and produces no write-back.
// Index 0 is read-as-zero in the register file, so it is never written.
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [IDX_W-1:0] rd,
    input  logic [WIDTH-1:0] rs_a_data,
    input  logic [WIDTH-1:0] rs_b_data,
    output logic             write_enable,
    output logic [IDX_W-1:0] write_index,
    output logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic             err
);

    state_t           state_q, state_d;
    logic             wen_q, wen_d;
    logic [IDX_W-1:0] widx_q, widx_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             err_q, err_d;
    logic             accept_s;
    logic [WIDTH-1:0] alu_s;

    assign in_ready     = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign accept_s     = in_valid && (state_q == S_IDLE);
    assign write_enable = wen_q;
    assign write_index  = widx_q;
    assign write_data   = wdata_q;
    assign err          = err_q;

    // Single-cycle ALU result from the live operands; wraps modulo 2^WIDTH.
    always_comb begin
        alu_s = '0;
        case (op_t'(op))
            OP_ADD:  alu_s = rs_a_data + rs_b_data;
            OP_SUB:  alu_s = rs_a_data - rs_b_data;
            OP_AND:  alu_s = rs_a_data & rs_b_data;
            default: alu_s = '0;
        endcase
    end

`ifdef EXEC_MUL_EN
    logic             mul_start_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_product_s;
    logic [IDX_W-1:0] rd_q;

    assign mul_start_s = accept_s && (op_t'(op) == OP_MUL);

    mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul_seq (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (mul_start_s),
        .a_i      (rs_a_data),
        .b_i      (rs_b_data),
        .done_o   (mul_done_s),
        .product_o(mul_product_s)
    );

    // Destination index held for the multi-cycle multiply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else if (accept_s) begin
            rd_q <= rd;
        end
    end
`endif

    // Next state and next write-back beat; write fields stay zero unless a write is issued.
    always_comb begin
        state_d = state_q;
        wen_d   = 1'b0;
        widx_d  = '0;
        wdata_d = '0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    if (op_t'(op) == OP_MUL) begin
`ifdef EXEC_MUL_EN
                        state_d = S_MUL;
`else
                        err_d   = 1'b1;
`endif
                    end else begin
                        state_d = S_WB;
                        if (rd != '0) begin
                            wen_d   = 1'b1;
                            widx_d  = rd;
                            wdata_d = alu_s;
                        end else begin
                            wen_d = 1'b0;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
`ifdef EXEC_MUL_EN
                if (mul_done_s) begin
                    state_d = S_WB;
                    if (rd_q != '0) begin
                        wen_d   = 1'b1;
                        widx_d  = rd_q;
                        wdata_d = mul_product_s;
                    end else begin
                        wen_d = 1'b0;
                    end
                end else begin
                    state_d = S_MUL;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wen_q   <= 1'b0;
            widx_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed and randomized checks of exec_unit against a
// latency/result reference model. Honors EXEC_MUL_EN like the design.
module tb_exec_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [1:0]  rd;
    logic [31:0] rs_a_data;
    logic [31:0] rs_b_data;
    logic        write_enable;
    logic [1:0]  write_index;
    logic [31:0] write_data;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    exec_unit #(.WIDTH(32), .IDX_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .rd          (rd),
        .rs_a_data   (rs_a_data),
        .rs_b_data   (rs_b_data),
        .write_enable(write_enable),
        .write_index (write_index),
        .write_data  (write_data),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference result: plain arithmetic modulo 2^32.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint unsigned prod;
        prod = 64'(a) * 64'(b);
        case (o)
            2'd0:    ref_result = a + b;
            2'd1:    ref_result = a - b;
            2'd2:    ref_result = a & b;
            default: ref_result = prod[31:0];
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(4, 0))
            0:       pick_operand = 32'hFFFF_FFFF;
            1:       pick_operand = 32'h0000_0000;
            2:       pick_operand = 32'h0000_0001;
            3:       pick_operand = 32'h8000_0000;
            default: pick_operand = $urandom;
        endcase
    endfunction

    // Present one operation in an idle cycle and follow it until the unit is idle again.
    task automatic run_op(input logic [1:0] o, input logic [1:0] r, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_v;
        int          lat;
        logic        wb;
        exp_v = ref_result(o, a, b);
        check_eq("ready_before_accept", 64'(in_ready), 64'd1);
        op = o; rd = r; rs_a_data = a; rs_b_data = b; in_valid = 1'b1;
        @(posedge clk); #1;
        // Garbage with in_valid held high while busy: must be ignored.
        op = 2'($urandom_range(3, 0)); rd = 2'($urandom_range(3, 0));
        rs_a_data = $urandom; rs_b_data = $urandom;
`ifdef EXEC_MUL_EN
        lat = (o == 2'd3) ? 33 : 1;
`else
        if (o == 2'd3) begin
            in_valid = 1'b0;
            check_eq("err_pulse", 64'(err), 64'd1);
            check_eq("err_no_write", 64'(write_enable), 64'd0);
            check_eq("err_ready", 64'(in_ready), 64'd1);
            check_eq("err_not_busy", 64'(busy), 64'd0);
            @(posedge clk); #1;
            check_eq("err_cleared", 64'(err), 64'd0);
            check_eq("err_no_write2", 64'(write_enable), 64'd0);
            return;
        end
        lat = 1;
`endif
        for (int k = 1; k <= lat; k++) begin
            wb = (k == lat) && (r != 2'd0);
            check_eq("busy", 64'(busy), 64'd1);
            check_eq("ready_low", 64'(in_ready), 64'd0);
            check_eq("wen", 64'(write_enable), 64'(wb));
            check_eq("widx", 64'(write_index), wb ? 64'(r) : 64'd0);
            check_eq("wdata", 64'(write_data), wb ? 64'(exp_v) : 64'd0);
            check_eq("err_quiet", 64'(err), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("idle_ready", 64'(in_ready), 64'd1);
        check_eq("idle_busy", 64'(busy), 64'd0);
        check_eq("idle_wen", 64'(write_enable), 64'd0);
        check_eq("idle_wdata", 64'(write_data), 64'd0);
    endtask

    initial begin
        logic saw_wen;
        rst = 1'b1; in_valid = 1'b0; op = 2'd0; rd = 2'd0;
        rs_a_data = 32'd0; rs_b_data = 32'd0;
        #2;
        check_eq("rst_wen", 64'(write_enable), 64'd0);
        check_eq("rst_widx", 64'(write_index), 64'd0);
        check_eq("rst_wdata", 64'(write_data), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_release_ready", 64'(in_ready), 64'd1);

        // Directed cases.
        run_op(2'd0, 2'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op(2'd1, 2'd2, 32'h0000_0003, 32'h0000_0005);
        run_op(2'd2, 2'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
        run_op(2'd0, 2'd0, 32'h0000_0007, 32'h0000_0008);
        run_op(2'd3, 2'd3, 32'h0001_0003, 32'h0001_0005);
        run_op(2'd3, 2'd0, 32'h0000_1234, 32'h0000_5678);

        // Randomized operations, back to back.
        for (int i = 0; i < 30; i++) begin
            run_op(2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), pick_operand(), pick_operand());
        end

        // Reset during a single-cycle write-back beat.
        op = 2'd0; rd = 2'd1; rs_a_data = 32'd1; rs_b_data = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("wb_before_rst", 64'(write_enable), 64'd1);
        #3 rst = 1'b1;
        #1;
        check_eq("async_rst_wen", 64'(write_enable), 64'd0);
        check_eq("async_rst_wdata", 64'(write_data), 64'd0);
        check_eq("async_rst_widx", 64'(write_index), 64'd0);
        check_eq("async_rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("post_rst_ready", 64'(in_ready), 64'd1);

`ifdef EXEC_MUL_EN
        // Reset in the 10th multiply cycle aborts without a write-back.
        op = 2'd3; rd = 2'd2; rs_a_data = 32'd9; rs_b_data = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
        end
        check_eq("mul_busy_c10", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("mul_rst_busy", 64'(busy), 64'd0);
        check_eq("mul_rst_ready", 64'(in_ready), 64'd1);
        check_eq("mul_rst_wen", 64'(write_enable), 64'd0);
        check_eq("mul_rst_wdata", 64'(write_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw_wen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (write_enable) saw_wen = 1'b1;
            @(posedge clk); #1;
        end
        check_eq("mul_rst_no_wb", 64'(saw_wen), 64'd0);
        check_eq("mul_rst_ready_after", 64'(in_ready), 64'd1);
`endif

        // Unit still works after the resets.
        run_op(2'd1, 2'd3, 32'h0000_0000, 32'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
